// File: rtl/spi_pkg.sv
// spi_pkg: shared frame constants and controller state encoding for the SPI master.
package spi_pkg;
  localparam int FRAME_LEN = 17;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period divider producing sclk plus single-cycle rise/fall strobes.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic run,
  output logic sclk,
  output logic tick,
  output logic rise_en,
  output logic fall_en
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] r_div;
  // tick marks the last cycle of a half-period; sclk only toggles while run is high
  assign tick = en && (r_div == W'(CLK_DIV - 1));
  assign rise_en = run && tick && !sclk;
  assign fall_en = run && tick && sclk;
  always_ff @(posedge clk)
    if (!rst_n || !en) begin
      r_div <= '0;
      sclk <= 1'b0;
    end else begin
      r_div <= tick ? '0 : r_div + 1'b1;
      if (run && tick) sclk <= !sclk;
    end
endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master sending {rw, addr, data} frames and capturing read data.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              ss,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata
);
  state_t r_state;
  logic [4:0] r_cnt;
  logic [FRAME_LEN-1:0] r_tx;
  logic r_rw;
  logic w_act, w_tick, w_rise, w_fall;
  assign w_act = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);
  assign busy = w_act;
  assign ss = !w_act;
  assign done = r_state == DONE;
  assign mosi = w_act && r_tx[FRAME_LEN-1];
  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (w_act),
    .run    (r_state == SHIFT),
    .sclk   (sclk),
    .tick   (w_tick),
    .rise_en(w_rise),
    .fall_en(w_fall)
  );
  // r_cnt counts completed rising edges; data-phase sampling covers rises 10..17
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_tx <= '0;
      r_rw <= 1'b0;
      rdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= SETUP;
          r_cnt <= '0;
          r_rw <= rw;
          r_tx <= {rw, addr, rw ? wdata : {DATA_W{1'b0}}};
        end
        SETUP: if (w_tick) r_state <= SHIFT;
        SHIFT: begin
          if (w_rise) begin
            r_cnt <= r_cnt + 5'd1;
            if (!r_rw && r_cnt >= 5'(ADDR_W + 1)) rdata <= {rdata[DATA_W-2:0], miso};
          end
          if (w_fall) begin
            r_tx <= r_tx << 1;
            if (r_cnt == 5'(FRAME_LEN)) r_state <= HOLD;
          end
        end
        HOLD: if (w_tick) r_state <= DONE;
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period (legal values: 2 or more).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: transaction request, sampled in IDLE only.
REQ-005 SHALL have port rw, input, 1 bit: 1 = write, 0 = read; latched on accepted start.
REQ-006 SHALL have port addr, input, 8 bits: target address; latched on accepted start.
REQ-007 SHALL have port wdata, input, 8 bits: write data; latched on accepted start.
REQ-008 SHALL have port miso, input, 1 bit: serial data from the slave.
REQ-009 SHALL have port sclk, output, 1 bit: serial clock; idle low.
REQ-010 SHALL have port mosi, output, 1 bit: serial data to the slave, MSB first.
REQ-011 SHALL have port ss, output, 1 bit: slave select, active-low.
REQ-012 SHALL have port busy, output, 1 bit: high from the accepted start until the cycle before done.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port rdata, output, 8 bits: read result; valid when done pulses after a read.

Function
REQ-015 SHALL send a 17-bit frame: rw bit, then addr[7:0], then the data byte; every field goes MSB first.
REQ-016 SHALL use SPI mode 0: mosi changes only while sclk is low; miso is sampled on each sclk rising edge.
REQ-017 SHALL use the states IDLE, SETUP, SHIFT, HOLD and DONE.
REQ-018 In IDLE, start=1 SHALL latch rw, addr and wdata; on the next cycle ss=0, mosi=rw, busy=1, and the state moves to SETUP.
REQ-019 SETUP SHALL last CLK_DIV cycles with sclk low, then move to SHIFT.
REQ-020 SHIFT SHALL produce 17 sclk periods (each CLK_DIV low, then CLK_DIV high).
  - On each falling edge, mosi SHALL advance to the next frame bit.
REQ-021 For a read, SHALL sample miso into rdata on the rising edges of bits 10-17 (the data phase), MSB first.
  - In the data phase mosi SHALL be 0.
REQ-022 For a write, SHALL leave rdata unchanged.
REQ-023 After the 17th high half-period, SHALL drive sclk low and stay in HOLD for CLK_DIV cycles with ss=0.
REQ-024 From HOLD, SHALL enter DONE: ss=1, busy=0, done=1 for exactly one cycle, then return to IDLE.
REQ-025 The done cycle SHALL be exactly 36*CLK_DIV+1 cycles after the accepted start cycle (145 for CLK_DIV=4).
REQ-026 SHALL ignore start while busy=1 or in DONE; a start in the cycle after DONE SHALL be accepted.
REQ-027 SHALL drive mosi=0 whenever ss=1.
REQ-028 SHALL use a 5-bit bit counter and a CLK_DIV-width divider counter, with no wrap beyond 17 bits.

Reset
REQ-029 When rst_n=0 at a clk edge, SHALL force IDLE, sclk=0, ss=1, mosi=0, busy=0, done=0, rdata=0, and clear all counters.
REQ-030 Reset mid-transaction SHALL abort the frame immediately, with no done pulse and no partial rdata update after reset.

Structure
REQ-031 SHALL take the state enum and the constants FRAME_LEN=17, ADDR_W=8 and DATA_W=8 from shared package spi_pkg.
REQ-032 SHALL place SCLK generation in one sub-module, spi_clk_gen, which outputs single-cycle rise_en and fall_en strobes.

Verification
REQ-033 Write: rw=1, addr=233, wdata=0xB9 -> mosi sequence 1,11101001,10111001 captured on sclk rises; done at start+145; rdata unchanged.
REQ-034 Read: slave model stores 185 at address 233; rw=0, addr=233 -> rdata=0xB9 at done; 17 sclk rising edges seen.
REQ-035 start pulsed at cycles 10 and 60 of a transaction -> only the first is accepted; exactly one done pulse.
REQ-036 rst_n=0 during bit 5 -> next cycle ss=1, sclk=0, busy=0; no done; a new start then completes normally.
REQ-037 Back-to-back: start held high -> second ss falling edge 2 cycles after the first done; both frames correct.
REQ-038 CLK_DIV=2 read of a slave returning 0x5A -> rdata=0x5A; done at start+73.
